// File: rtl/uart_pos_pkg.sv
// Shared types and helpers for the UART position assembler.
package uart_pos_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam int         PKT_PAYLOAD_BYTES = 4;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] x;
  } pos_t;

  // raw = {y_hi, y_lo, x_hi, x_lo}; each axis clamped independently, unsigned.
  function automatic pos_t clamp_pos(input logic [31:0] raw,
                                     input logic [15:0] x_max,
                                     input logic [15:0] y_max);
    pos_t p;
    p.x = (raw[15:0]  > x_max) ? x_max : raw[15:0];
    p.y = (raw[31:16] > y_max) ? y_max : raw[31:16];
    return p;
  endfunction

endpackage

// File: rtl/uart_pos_assembler_pkt_timeout.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYC cycles have elapsed.
module pkt_timeout #(
  parameter int unsigned TIMEOUT_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == W'(TIMEOUT_CYC));

endmodule

// File: rtl/uart_pos_assembler.sv
// Frames UART bytes into {y,x} position packets, checks and clamps them, and
// commits the latest good packet to the renderer only at frame_start.
module uart_pos_assembler
  import uart_pos_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 250000,
  parameter logic [15:0] X_MAX       = 16'd440,
  parameter logic [15:0] Y_MAX       = 16'd330,
  parameter logic [15:0] INIT_X      = 16'd0,
  parameter logic [15:0] INIT_Y      = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        frame_start,
  output logic [31:0] uart_buf,
  output logic        buf_update,
  output logic        pkt_err,
  output logic [7:0]  err_count
);

  // state   | meaning
  // IDLE    | hunting for SYNC_BYTE, everything else ignored
  // PAYLOAD | collecting x_lo, x_hi, y_lo, y_hi (SYNC_BYTE is plain data)
  // CHECK   | next byte is the XOR checksum of the payload

  state_t      state, state_nx;
  logic [1:0]  idx;
  logic [7:0]  csum;
  logic [31:0] payload;
  pos_t        pending;
  logic        pending_valid;
  logic        accept, drop, expired;

  pkt_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid || (state == IDLE)),
    .enable  (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        if (rx_valid) begin
          if (idx == 2'(PKT_PAYLOAD_BYTES - 1)) state_nx = CHECK;
        end else if (expired) begin
          drop     = 1'b1;
          state_nx = IDLE;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum) accept = 1'b1;
          else                 drop   = 1'b1;
          state_nx = IDLE;
        end else if (expired) begin
          drop     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      csum    <= '0;
      payload <= '0;
    end else if (rx_valid) begin
      if (state == IDLE) begin
        idx  <= '0;
        csum <= '0;
      end else if (state == PAYLOAD) begin
        payload[{idx, 3'b000} +: 8] <= rx_data;
        csum <= csum ^ rx_data;
        idx  <= idx + 2'd1;
      end
    end
  end

  // Commit uses the pending value from before this edge; a same-cycle accept
  // then refills pending for the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_buf      <= {INIT_Y, INIT_X};
      buf_update    <= 1'b0;
      pkt_err       <= 1'b0;
      err_count     <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      buf_update <= 1'b0;
      pkt_err    <= drop;
      if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (frame_start && pending_valid) begin
        uart_buf      <= pending;
        buf_update    <= 1'b1;
        pending_valid <= 1'b0;
      end
      if (accept) begin
        pending       <= clamp_pos(payload, X_MAX, Y_MAX);
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_pos_assembler.sv
// Self-checking bench for uart_pos_assembler: directed cases plus randomized
// packet traffic compared against a byte-queue reference model.
module tb_uart_pos_assembler;

  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam int          TMO    = 200;
  localparam logic [15:0] XMAX   = 16'd440;
  localparam logic [15:0] YMAX   = 16'd330;
  localparam logic [15:0] INIT_X = 16'h0011;
  localparam logic [15:0] INIT_Y = 16'h0022;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] uart_buf;
  logic        buf_update;
  logic        pkt_err;
  logic [7:0]  err_count;

  uart_pos_assembler #(
    .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO), .X_MAX(XMAX), .Y_MAX(YMAX),
    .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_start(frame_start), .uart_buf(uart_buf), .buf_update(buf_update),
    .pkt_err(pkt_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes of the packet in progress, pending/committed position.
  logic [7:0]  q[$];
  logic [31:0] mp;
  logic        mpv;
  logic [31:0] mbuf;
  int          merr, mdrops, mcommits;
  int          err_pulses = 0, upd_pulses = 0;

  always @(negedge clk) begin
    if (pkt_err)    err_pulses++;
    if (buf_update) upd_pulses++;
  end

  task automatic model_reset();
    q.delete();
    mpv  = 1'b0;
    mp   = '0;
    mbuf = {INIT_Y, INIT_X};
    merr = 0;
  endtask

  task automatic model_drop();
    mdrops++;
    if (merr < 255) merr++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int x, y;
    if (q.size() == 0) begin
      if (b == SYNC) q.push_back(b);
    end else begin
      q.push_back(b);
    end
    if (q.size() == 6) begin
      if (q[5] == (q[1] ^ q[2] ^ q[3] ^ q[4])) begin
        x = {q[2], q[1]};
        y = {q[4], q[3]};
        if (x > int'(XMAX)) x = int'(XMAX);
        if (y > int'(YMAX)) y = int'(YMAX);
        mp  = {16'(y), 16'(x)};
        mpv = 1'b1;
      end else begin
        model_drop();
      end
      q.delete();
    end
  endtask

  task automatic model_timeout();
    if (q.size() != 0) begin
      model_drop();
      q.delete();
    end
  endtask

  task automatic model_frame();
    if (mpv) begin
      mbuf = mp;
      mpv  = 1'b0;
      mcommits++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs);
    logic commit;
    commit      = fs && mpv;
    rx_data     = b;
    rx_valid    = 1'b1;
    frame_start = fs;
    if (fs) model_frame();
    model_byte(b);
    @(negedge clk);
    rx_valid    = 1'b0;
    frame_start = 1'b0;
    if (fs) begin
      check("byte_frame_upd", 32'(buf_update), 32'(commit));
      check("byte_frame_buf", uart_buf, mbuf);
    end
  endtask

  task automatic frame();
    logic commit;
    commit      = mpv;
    frame_start = 1'b1;
    model_frame();
    @(negedge clk);
    frame_start = 1'b0;
    check("frame_upd", 32'(buf_update), 32'(commit));
    check("frame_buf", uart_buf, mbuf);
  endtask

  task automatic send_pkt(input logic [15:0] x, input logic [15:0] y, input logic [7:0] cs_flip);
    logic [7:0] cs;
    cs = x[7:0] ^ x[15:8] ^ y[7:0] ^ y[15:8] ^ cs_flip;
    send_byte(SYNC, 1'b0);
    send_byte(x[7:0], 1'b0);
    send_byte(x[15:8], 1'b0);
    send_byte(y[7:0], 1'b0);
    send_byte(y[15:8], 1'b0);
    send_byte(cs, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_packet();
    logic [15:0] x, y;
    logic [7:0]  pkt[6];
    logic [7:0]  junk;
    logic        bad, trunc;
    int          n;
    x = ($urandom_range(0, 3) == 0) ? 16'(int'(XMAX) + int'($urandom_range(0, 2)) - 1) : 16'($urandom);
    y = ($urandom_range(0, 3) == 0) ? 16'(int'(YMAX) + int'($urandom_range(0, 2)) - 1) : 16'($urandom);
    bad   = ($urandom_range(0, 3) == 0);
    trunc = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 2) == 0) begin
      junk = 8'($urandom);
      if (junk == SYNC) junk = 8'h5A;
      send_byte(junk, 1'b0);
    end
    pkt[0] = SYNC;
    pkt[1] = x[7:0];
    pkt[2] = x[15:8];
    pkt[3] = y[7:0];
    pkt[4] = y[15:8];
    pkt[5] = x[7:0] ^ x[15:8] ^ y[7:0] ^ y[15:8];
    if (bad) pkt[5] = pkt[5] ^ (8'h01 << $urandom_range(0, 7));
    n = trunc ? int'($urandom_range(1, 5)) : 6;
    for (int i = 0; i < n; i++) begin
      send_byte(pkt[i], $urandom_range(0, 9) == 0);
      idle($urandom_range(0, 6));
    end
    if (trunc) begin
      idle(TMO + 10);
      model_timeout();
    end
    check("rand_err_count", 32'(err_count), 32'(merr));
    if ($urandom_range(0, 2) == 0) frame();
  endtask

  initial begin
    mdrops = 0;
    mcommits = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    check("reset_buf", uart_buf, {INIT_Y, INIT_X});
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_upd", 32'(buf_update), 32'd0);
    check("reset_pkt_err", 32'(pkt_err), 32'd0);

    // good packet, commit at frame_start, one-cycle pulse
    send_pkt(16'h0064, 16'h0032, 8'h00);
    check("good_no_err", 32'(pkt_err), 32'd0);
    check("good_buf_held", uart_buf, {INIT_Y, INIT_X});
    frame();
    check("good_buf_value", uart_buf, 32'h0032_0064);
    @(negedge clk);
    check("upd_one_cycle", 32'(buf_update), 32'd0);

    // bad checksum
    send_pkt(16'h0064, 16'h0032, 8'h01);
    check("bad_pkt_err", 32'(pkt_err), 32'd1);
    check("bad_err_count", 32'(err_count), 32'd1);
    @(negedge clk);
    check("bad_pkt_err_pulse", 32'(pkt_err), 32'd0);
    frame();

    // clamping of both axes
    send_pkt(16'h0300, 16'h0200, 8'h00);
    frame();
    check("clamp_value", uart_buf, 32'h014A_01B8);
    send_pkt(XMAX, YMAX, 8'h00);
    frame();
    check("clamp_edge", uart_buf, {YMAX, XMAX});

    // a gap just under the timeout is tolerated
    send_byte(SYNC, 1'b0);
    send_byte(8'h10, 1'b0);
    idle(TMO - 5);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b0);
    check("gap_ok_err_count", 32'(err_count), 32'(merr));
    frame();

    // timeout drops the partial packet
    send_byte(SYNC, 1'b0);
    send_byte(8'h64, 1'b0);
    idle(TMO - 5);
    check("tmo_not_yet", 32'(err_count), 32'(merr));
    idle(15);
    model_timeout();
    check("tmo_err_count", 32'(err_count), 32'(merr));
    send_pkt(16'd77, 16'd88, 8'h00);
    frame();
    check("tmo_then_good", uart_buf, {16'd88, 16'd77});

    // latest wins, then accept on the same cycle as frame_start
    send_pkt(16'd10, 16'd5, 8'h00);
    send_pkt(16'd20, 16'd5, 8'h00);
    frame();
    check("latest_wins", uart_buf, {16'd5, 16'd20});
    send_pkt(16'd40, 16'd6, 8'h00);
    send_byte(SYNC, 1'b0);
    send_byte(8'd50, 1'b0);
    send_byte(8'd0, 1'b0);
    send_byte(8'd7, 1'b0);
    send_byte(8'd0, 1'b0);
    send_byte(8'd50 ^ 8'd7, 1'b1);
    check("simul_old_commit", uart_buf, {16'd6, 16'd40});
    frame();
    check("simul_new_next", uart_buf, {16'd7, 16'd50});
    frame();

    // reset mid-payload, then a stream with leading noise
    send_byte(SYNC, 1'b0);
    send_byte(8'h64, 1'b0);
    send_byte(8'h00, 1'b0);
    do_reset();
    check("midrst_buf", uart_buf, {INIT_Y, INIT_X});
    check("midrst_err_count", 32'(err_count), 32'd0);
    begin
      logic [7:0] s[8];
      s = '{8'h00, 8'hA5, 8'hA5, 8'h64, 8'h00, 8'h32, 8'h00, 8'h56};
      foreach (s[i]) send_byte(s[i], 1'b0);
    end
    check("stream_err_count", 32'(err_count), 32'(merr));
    frame();
    send_pkt(16'h0064, 16'h0032, 8'h00);
    frame();
    check("resync_good", uart_buf, 32'h0032_0064);

    for (int k = 0; k < 60; k++) rand_packet();
    frame();

    // saturation
    for (int k = 0; k < 256; k++) send_pkt(16'($urandom), 16'($urandom), 8'h80);
    check("sat_err_count", 32'(err_count), 32'h0000_00FF);
    send_pkt(16'd1, 16'd2, 8'h04);
    check("sat_pulse", 32'(pkt_err), 32'd1);
    check("sat_hold", 32'(err_count), 32'h0000_00FF);
    check("sat_model", 32'(err_count), 32'(merr));

    idle(2);
    check("err_pulse_total", 32'(err_pulses), 32'(mdrops));
    check("upd_pulse_total", 32'(upd_pulses), 32'(mcommits));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
